// File: rtl/adc_serial_reg_receiver_pkg.sv
// Shared definitions for the ADC 3-wire serial register bus receiver:
// frame layout constants, FSM state encoding and header decode helper.
package adc_serial_reg_receiver_pkg;

  localparam int HEADER_BITS = 12;
  localparam logic [HEADER_BITS-1:0] HEADER_DEFAULT = 12'h001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_DESEL
  } state_t;

  function automatic logic header_match(input logic [HEADER_BITS-1:0] field,
                                        input logic [HEADER_BITS-1:0] header);
    return field == header;
  endfunction

endpackage

// File: rtl/adc_serial_reg_receiver_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous bus line, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module adc_serial_reg_receiver_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: the synchronizer flops carry no reset so they keep tracking the
  // real line level during reset; only the edge pulses are cleared.
  always_ff @(posedge Clock) begin
    chain <= {chain[STAGES-2:0], din};
    prev  <= chain[STAGES-1];
  end

  assign sync = chain[STAGES-1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

endmodule

// File: rtl/adc_serial_reg_receiver.sv
// Oversampling receiver for the ADC serial register bus: decodes 32-bit frames
// into writes to a shadow register file and flags malformed frames.
module adc_serial_reg_receiver
  import adc_serial_reg_receiver_pkg::*;
#(
  parameter logic [HEADER_BITS-1:0] HEADER      = HEADER_DEFAULT,
  parameter int                     ADDR_BITS   = 4,
  parameter int                     DATA_BITS   = 16,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InSclk,
  input  logic                 InSdata,
  input  logic                 InSelect,
  input  logic [ADDR_BITS-1:0] RdAddr,
  output logic [DATA_BITS-1:0] RdData,
  output logic                 WrStrobe,
  output logic [ADDR_BITS-1:0] WrAddr,
  output logic [DATA_BITS-1:0] WrData,
  output logic                 FrameError,
  output logic                 Busy
);

  localparam int FRAME_BITS = HEADER_BITS + ADDR_BITS + DATA_BITS;
  localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);
  localparam int NUM_REGS   = 1 << ADDR_BITS;
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(FRAME_BITS - 1);

  logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
  logic sel_sync, sel_rise, sel_fall;

  adc_serial_reg_receiver_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .Clock (Clock),
    .Reset (Reset),
    .din   (InSclk),
    .sync  (sclk_sync_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  adc_serial_reg_receiver_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sel_sync (
    .Clock (Clock),
    .Reset (Reset),
    .din   (InSelect),
    .sync  (sel_sync),
    .rise  (sel_rise),
    .fall  (sel_fall)
  );

  // Same depth as Sclk plus one flop to match the registered edge pulse.
  logic [SYNC_STAGES-1:0] sdata_chain;
  logic                   sdata_bit;

  always_ff @(posedge Clock) begin
    sdata_chain <= {sdata_chain[SYNC_STAGES-2:0], InSdata};
    sdata_bit   <= sdata_chain[SYNC_STAGES-1];
  end

  state_t                  state, state_n;
  logic [CNT_BITS-1:0]     count, count_n;
  logic [FRAME_BITS-1:0]   shift, shift_n, frame_n;
  logic                    strobe_n, error_n;
  logic [ADDR_BITS-1:0]    addr_n;
  logic [DATA_BITS-1:0]    data_n;
  logic                    after_reset;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    count_n  = count;
    shift_n  = shift;
    strobe_n = 1'b0;
    error_n  = 1'b0;
    addr_n   = WrAddr;
    data_n   = WrData;
    frame_n  = {shift[FRAME_BITS-2:0], sdata_bit};

    unique case (state)
      ST_IDLE: begin
        if (sel_fall) begin
          state_n = ST_SHIFT;
          count_n = '0;
        end else if (after_reset && !sel_sync) begin
          state_n = ST_DESEL;
        end
      end
      ST_SHIFT: begin
        // The final bit wins over a simultaneous deselect; header is judged
        // on the completed frame so the verdict is visible while in CHECK.
        if (sclk_rise && count == LAST_BIT) begin
          shift_n = frame_n;
          count_n = count + 1'b1;
          state_n = ST_CHECK;
          if (header_match(frame_n[FRAME_BITS-1 -: HEADER_BITS], HEADER)) begin
            strobe_n = 1'b1;
            addr_n   = frame_n[DATA_BITS +: ADDR_BITS];
            data_n   = frame_n[DATA_BITS-1:0];
          end else begin
            error_n = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            shift_n = frame_n;
            count_n = count + 1'b1;
          end
          if (sel_rise) begin
            error_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_CHECK: state_n = sel_sync ? ST_IDLE : ST_DESEL;
      ST_DESEL: if (sel_sync) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      shift       <= '0;
      WrStrobe    <= 1'b0;
      FrameError  <= 1'b0;
      WrAddr      <= '0;
      WrData      <= '0;
      after_reset <= 1'b1;
    end else begin
      state       <= state_n;
      count       <= count_n;
      shift       <= shift_n;
      WrStrobe    <= strobe_n;
      FrameError  <= error_n;
      WrAddr      <= addr_n;
      WrData      <= data_n;
      after_reset <= 1'b0;
    end
  end

  assign Busy = (state != ST_IDLE);

  logic [DATA_BITS-1:0] shadow [NUM_REGS];

  // NOTE: the shadow file is a flop array that must read back zero after
  // reset, so it is cleared explicitly rather than left to power-up.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      RdData <= '0;
    end else begin
      if (WrStrobe) shadow[WrAddr] <= WrData;
      RdData <= shadow[RdAddr];
    end
  end

endmodule
